// File: rtl/reg_dump_if.sv
// Output stream of the register dump engine: one word plus its register
// index, moved under a valid/ready handshake.
interface reg_dump_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [D-1:0] out_addr;

    // Dump engine side: presents words and waits for the sink.
    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    // Sink side: accepts words by raising out_ready.
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Debug read-out engine for the register file. Walks a wrap-around index
// window through the spare combinational read port, streams each value out
// and keeps a running mod-2**W checksum. Holds off core writes while busy.
module reg_dump #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [D-1:0]  first,
    input  logic [D-1:0]  last,
    output logic [D-1:0]  rd_addr,
    input  logic [W-1:0]  rd_data,
    reg_dump_if.master    out_if,
    output logic          busy,
    output logic          hold,
    output logic          done,
    output logic [W-1:0]  checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [D-1:0] r_ptr;
    logic [D-1:0] r_last;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [D-1:0] r_out_addr;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_checksum;
    logic         w_handshake;

    // Outputs are driven straight from registers; the read address is the walk pointer.
    assign rd_addr          = r_ptr;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_addr  = r_out_addr;
    assign busy             = r_busy;
    assign hold             = r_busy;
    assign checksum         = r_checksum;
    assign w_handshake      = r_out_valid & out_if.out_ready;

    // The pulse register is set on entry to DONE; an abort seen during that
    // one DONE cycle masks it so a cancelled dump never reports completion.
    assign done = r_done & ~abort;

    // Dump state machine: window walk, output word register, checksum and status.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else if (abort && r_state != S_IDLE) begin
            // Cancel wins over any same-cycle handshake; checksum keeps its partial sum.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ptr      <= first;
                        r_last     <= last;
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_out_data  <= rd_data;
                    r_out_addr  <= r_ptr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_checksum  <= r_checksum + r_out_data;
                        r_out_valid <= 1'b0;
                        if (r_ptr == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_ptr + D'(1);
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a behavioural register file answers the read
// port, and each step checks the stream, status and checksum against values
// worked out by hand for the chosen register contents.
module tb_reg_dump;

    logic       CLK;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] first;
    logic [3:0] last;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       hold;
    logic       done;
    logic [7:0] checksum;
    logic [7:0] regs [16];

    int n_checks;
    int n_errors;

    reg_dump_if #(.W(8), .D(4)) out_if ();

    reg_dump #(.W(8), .D(4)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .first    (first),
        .last     (last),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_if   (out_if.master),
        .busy     (busy),
        .hold     (hold),
        .done     (done),
        .checksum (checksum)
    );

    assign rd_data = regs[rd_addr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Run one dump and check every word, the done timing and the final checksum.
    // exp_lat counts edges from the start edge (edge 1) to the edge that raises done.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int n,
                            input logic [7:0] exp_sum, input int exp_lat,
                            input int stall_word, input int stall_n, input bit poke);
        int         cnt;
        logic [3:0] a;
        first = f;
        last  = l;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 1;
        check("busy_after_start", busy, 1);
        check("hold_after_start", hold, 1);
        check("valid_in_read", out_if.out_valid, 0);
        for (int i = 0; i < n; i++) begin
            a = f + 4'(i);
            if (poke && i == 0) begin
                start = 1'b1;
                first = 4'd0;
                last  = 4'd3;
            end
            step();
            cnt++;
            start = 1'b0;
            check("word_valid", out_if.out_valid, 1);
            check("word_addr", out_if.out_addr, a);
            check("word_data", out_if.out_data, regs[a]);
            if (i == stall_word) begin
                out_if.out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    cnt++;
                    check("stall_valid", out_if.out_valid, 1);
                    check("stall_addr", out_if.out_addr, a);
                    check("stall_data", out_if.out_data, regs[a]);
                end
                out_if.out_ready = 1'b1;
            end
            step();
            cnt++;
            if (i < n - 1) begin
                check("valid_after_accept", out_if.out_valid, 0);
                check("no_early_done", done, 0);
            end
        end
        check("done_pulse", done, 1);
        check("done_latency", cnt, exp_lat);
        check("busy_in_done", busy, 1);
        step();
        check("done_cleared", done, 0);
        check("busy_fell", busy, 0);
        check("hold_fell", hold, 0);
        check("checksum", checksum, exp_sum);
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset_n          = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        first            = 4'd0;
        last             = 4'd0;
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3);

        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", out_if.out_valid, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_checksum", checksum, 0);
        reset_n = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Basic window 2..5: words 6,9,12,15 -> checksum 42, done at edge 9.
        run_dump(4'd2, 4'd5, 4, 8'd42, 9, -1, 0, 1'b0);

        // Wrap window 14..1 with every register 0x80: 4*0x80 = 0x200 -> 0x00.
        for (int i = 0; i < 16; i++) regs[i] = 8'h80;
        run_dump(4'd14, 4'd1, 4, 8'h00, 9, -1, 0, 1'b0);

        // Backpressure: second word stalled 3 cycles, latency 9+3.
        for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3);
        run_dump(4'd2, 4'd5, 4, 8'd42, 12, 1, 3, 1'b0);

        // Single word at 7 = 0xA5, with a start pulse ignored while busy.
        regs[7] = 8'hA5;
        run_dump(4'd7, 4'd7, 1, 8'hA5, 3, -1, 0, 1'b1);

        // Abort during SEND of the 2nd word of window 8..11 (24,27,30,33).
        first = 4'd8;
        last  = 4'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort_w0_data", out_if.out_data, 24);
        step();
        step();
        check("abort_w1_data", out_if.out_data, 27);
        abort = 1'b1;
        check("abort_masks_done", done, 0);
        step();
        abort = 1'b0;
        check("abort_valid", out_if.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_checksum", checksum, 24);
        step();
        check("abort_no_late_done", done, 0);
        check("abort_checksum_kept", checksum, 24);
        // New start accepted from IDLE after abort: register 3 holds 9.
        run_dump(4'd3, 4'd3, 1, 8'd9, 3, -1, 0, 1'b0);

        // Asynchronous reset between edges in the middle of SEND.
        first = 4'd2;
        last  = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_rst_valid", out_if.out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", out_if.out_valid, 0);
        check("arst_data", out_if.out_data, 0);
        check("arst_addr", out_if.out_addr, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_hold", hold, 0);
        check("arst_done", done, 0);
        check("arst_checksum", checksum, 0);
        #2;
        reset_n = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_if.out_valid, 0);
        step();
        check("post_rst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
